// File: rtl/cancel_req_sequencer_pkg.sv
// Shared types for the cancel-order request sequencer and its event FIFO.
// Also carries the cache request/result types it drives directly.
package cancel_req_sequencer_pkg;

   localparam int unsigned CID_W           = 10;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned CANCEL_ADDR_LSB = 4;
   localparam int unsigned DEPTH_DEF       = 8;
   localparam int unsigned TIMEOUT_DEF     = 64;

   typedef struct packed {
      logic [31:0] rdindex;
      logic [31:0] wrindex;
      logic [31:0] data;
      logic        rw;
      logic        valid;
   } cpu_req_type;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_result_type;

   typedef struct packed {
      logic             is_query;
      logic [CID_W-1:0] cid;
      logic [31:0]      amount;
   } cancel_ev_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } seq_state_e;

   // Client ID lands on cache index bits [13:4].
   function automatic logic [31:0] cid_to_addr(input logic [CID_W-1:0] cid);
      return {{(32 - CID_W - CANCEL_ADDR_LSB){1'b0}}, cid, {CANCEL_ADDR_LSB{1'b0}}};
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/cancel_req_sequencer_fifo.sv
// Event FIFO: circular storage with occupancy and a saturating merge into the tail entry.
module cancel_ev_fifo
   import cancel_req_sequencer_pkg::*;
#(
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  cancel_ev_t       push_ev,
   input  logic             merge,
   input  logic [31:0]      merge_amount,
   input  logic             pop,
   output cancel_ev_t       head_ev,
   output logic             tail_is_query,
   output logic [CID_W-1:0] tail_cid,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   cancel_ev_t       mem_q [DEPTH];
   cancel_ev_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] tail_ptr;

   assign tail_ptr      = wr_ptr_q - PTR_W'(1);
   assign head_ev       = mem_q[rd_ptr_q];
   assign tail_is_query = mem_q[tail_ptr].is_query;
   assign tail_cid      = mem_q[tail_ptr].cid;
   assign count         = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (merge) begin
         mem_d[tail_ptr].amount = sat_add(mem_q[tail_ptr].amount, merge_amount);
      end
      if (push) begin
         mem_d[wr_ptr_q] = push_ev;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/cancel_req_sequencer.sv
// Feeds buffered cancel accumulates and balance queries to the cache FSM one at a time,
// with a wait watchdog, query responses and tail merging of same-client accumulates.
module cancel_req_sequencer
   import cancel_req_sequencer_pkg::*;
#(
   parameter  int unsigned DEPTH       = DEPTH_DEF,
   parameter  int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
   localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ev_valid,
   output logic             ev_ready,
   input  logic             ev_is_query,
   input  logic [CID_W-1:0] ev_cid,
   input  logic [31:0]      ev_amount,
   output cpu_req_type      cpu_req,
   input  cpu_result_type   cpu_res,
   output logic             rsp_valid,
   output logic [CID_W-1:0] rsp_cid,
   output logic [31:0]      rsp_data,
   output logic             timeout_err,
   output logic [CNT_W-1:0] occupancy
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

   seq_state_e       state_q, state_d;
   cpu_req_type      req_q, req_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [CID_W-1:0] rsp_cid_q, rsp_cid_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             timeout_err_q, timeout_err_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   cancel_ev_t       head_ev;
   cancel_ev_t       push_ev;
   logic             tail_is_query;
   logic [CID_W-1:0] tail_cid;
   logic [CNT_W-1:0] count;
   logic             fifo_empty, head_in_flight, merge_hit, accept;
   logic             done, abort, pop;

   // The head counts as in flight from the IDLE cycle that latches it into cpu_req.
   assign fifo_empty     = (count == '0);
   assign head_in_flight = (state_q == ST_ISSUE) || ((state_q == ST_IDLE) && !fifo_empty);
   assign merge_hit      = !ev_is_query && !fifo_empty && !tail_is_query && (tail_cid == ev_cid)
                           && !((count == CNT_W'(1)) && head_in_flight);
   assign ev_ready       = (count < CNT_W'(DEPTH)) || merge_hit;
   assign accept         = ev_valid && ev_ready;

   assign done  = (state_q == ST_ISSUE) && cpu_res.ready;
   assign abort = (state_q == ST_ISSUE) && !cpu_res.ready && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
   assign pop   = done || abort;

   assign push_ev = '{is_query: ev_is_query, cid: ev_cid, amount: ev_amount};

   cancel_ev_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .push          (accept && !merge_hit),
      .push_ev       (push_ev),
      .merge         (accept && merge_hit),
      .merge_amount  (ev_amount),
      .pop           (pop),
      .head_ev       (head_ev),
      .tail_is_query (tail_is_query),
      .tail_cid      (tail_cid),
      .count         (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
         ST_ISSUE: if (pop)         state_d = ST_GAP;
         ST_GAP:                    state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_d         = req_q;
      wait_d        = wait_q;
      rsp_valid_d   = 1'b0;
      rsp_cid_d     = rsp_cid_q;
      rsp_data_d    = rsp_data_q;
      timeout_err_d = timeout_err_q | abort;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               req_d.rdindex = cid_to_addr(head_ev.cid);
               req_d.wrindex = cid_to_addr(head_ev.cid);
               req_d.data    = head_ev.is_query ? 32'h0 : head_ev.amount;
               req_d.rw      = !head_ev.is_query;
               req_d.valid   = 1'b1;
               wait_d        = '0;
            end
         end
         ST_ISSUE: begin
            if (pop) begin
               req_d.valid = 1'b0;
               wait_d      = '0;
               if (done && head_ev.is_query) begin
                  rsp_valid_d = 1'b1;
                  rsp_cid_d   = head_ev.cid;
                  rsp_data_d  = cpu_res.data;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: req_d.valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q         <= '0;
         wait_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_cid_q     <= '0;
         rsp_data_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         req_q         <= req_d;
         wait_q        <= wait_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_cid_q     <= rsp_cid_d;
         rsp_data_q    <= rsp_data_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign cpu_req     = req_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_cid     = rsp_cid_q;
   assign rsp_data    = rsp_data_q;
   assign timeout_err = timeout_err_q;
   assign occupancy   = count;

endmodule
